// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the 8237A-compatible DMA channel arbiter.
package DmaPackage;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CH_W   = 2;

   localparam int unsigned CMD_DISABLE   = 2;
   localparam int unsigned CMD_ROTATE    = 4;
   localparam int unsigned CMD_DREQ_LOW  = 6;
   localparam int unsigned CMD_DACK_HIGH = 7;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_SERVICE
   } arbState_t;

   function automatic logic [NUM_CH-1:0] oneHot(input logic [CH_W-1:0] ch);
      return NUM_CH'(1) << ch;
   endfunction

endpackage

// File: rtl/dma_priority_arbiter_encoder.sv
// Combinational priority search: fixed (ch0 first) or rotating from ptr.
module dma_priority_encoder
   import DmaPackage::*;
(
   input  logic [NUM_CH-1:0] pending,
   input  logic [CH_W-1:0]   ptr,
   input  logic              rotate,
   output logic [CH_W-1:0]   winner,
   output logic              any
);

   logic [CH_W-1:0] base;
   logic [CH_W-1:0] idx;

   // Scan from lowest to highest priority so the highest-priority hit lands last.
   always_comb begin
      winner = '0;
      idx    = '0;
      any    = |pending;
      base   = rotate ? ptr : '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = base + CH_W'(i);
         if (pending[idx]) begin
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel request arbiter: syncs DREQ, resolves one channel, holds the
// grant for a full service and drives DACK with programmable polarity.
module dma_priority_arbiter #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] dreq,
   input  logic [7:0]        commandReg,
   input  logic [NUM_CH-1:0] maskReg,
   input  logic [NUM_CH-1:0] requestReg,
   input  logic              validDack,
   input  logic              cycleDone,
   output logic [NUM_CH-1:0] validDreq,
   output logic [NUM_CH-1:0] dack,
   output logic [CH_W-1:0]   grantCh,
   output logic              grantValid,
   output logic [CH_W-1:0]   prioPtr
);

   import DmaPackage::*;

   arbState_t         state;
   arbState_t         stateNext;
   logic [NUM_CH-1:0] dreqSync;
   logic [NUM_CH-1:0] dackInt;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] validDreqNext;
   logic [NUM_CH-1:0] dackIntNext;
   logic [CH_W-1:0]   grantChNext;
   logic [CH_W-1:0]   prioPtrNext;
   logic [CH_W-1:0]   winner;
   logic              anyPending;
   logic              ctrlDisable;
   logic              rotateMode;
   logic              unusedCmdBits;

   assign ctrlDisable   = commandReg[CMD_DISABLE];
   assign rotateMode    = commandReg[CMD_ROTATE];
   assign unusedCmdBits = ^{commandReg[1:0], commandReg[3], commandReg[5]};

   // Software requests bypass the mask.
   assign pending = (dreqSync & ~maskReg) | requestReg;

   assign dack = commandReg[CMD_DACK_HIGH] ? dackInt : ~dackInt;

   dma_priority_encoder uEncoder (
      .pending (pending),
      .ptr     (prioPtr),
      .rotate  (rotateMode),
      .winner  (winner),
      .any     (anyPending)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ARB_IDLE;
         dreqSync   <= '0;
         validDreq  <= '0;
         dackInt    <= '0;
         grantCh    <= '0;
         grantValid <= 1'b0;
         prioPtr    <= '0;
      end else begin
         state      <= stateNext;
         dreqSync   <= commandReg[CMD_DREQ_LOW] ? ~dreq : dreq;
         validDreq  <= validDreqNext;
         dackInt    <= dackIntNext;
         grantCh    <= grantChNext;
         grantValid <= (stateNext != ARB_IDLE);
         prioPtr    <= prioPtrNext;
      end
   end

   always_comb begin
      stateNext     = state;
      validDreqNext = validDreq;
      dackIntNext   = dackInt;
      grantChNext   = grantCh;
      prioPtrNext   = prioPtr;

      unique case (state)
         ARB_IDLE: begin
            validDreqNext = '0;
            dackIntNext   = '0;
            if (!ctrlDisable && anyPending) begin
               grantChNext   = winner;
               validDreqNext = oneHot(winner);
               stateNext     = ARB_GRANT;
            end
         end

         // Acknowledge wins over a request withdrawn in the same cycle.
         ARB_GRANT: begin
            if (validDack) begin
               dackIntNext = oneHot(grantCh);
               stateNext   = ARB_SERVICE;
            end else if (!pending[grantCh] || ctrlDisable) begin
               validDreqNext = '0;
               stateNext     = ARB_IDLE;
            end
         end

         // Service runs to completion; the finished channel drops to lowest priority.
         ARB_SERVICE: begin
            if (cycleDone) begin
               validDreqNext = '0;
               dackIntNext   = '0;
               stateNext     = ARB_IDLE;
               if (rotateMode) begin
                  prioPtrNext = grantCh + CH_W'(1);
               end
            end
         end

         default: begin
            validDreqNext = '0;
            dackIntNext   = '0;
            stateNext     = ARB_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter.
module tb_dma_priority_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] dreq;
   logic [7:0] commandReg;
   logic [3:0] maskReg;
   logic [3:0] requestReg;
   logic       validDack;
   logic       cycleDone;
   logic [3:0] validDreq;
   logic [3:0] dack;
   logic [1:0] grantCh;
   logic       grantValid;
   logic [1:0] prioPtr;

   int checkCount = 0;
   int errorCount = 0;

   dma_priority_arbiter dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .dreq       (dreq),
      .commandReg (commandReg),
      .maskReg    (maskReg),
      .requestReg (requestReg),
      .validDack  (validDack),
      .cycleDone  (cycleDone),
      .validDreq  (validDreq),
      .dack       (dack),
      .grantCh    (grantCh),
      .grantValid (grantValid),
      .prioPtr    (prioPtr)
   );

   always #5 CLK = ~CLK;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Bounded wait for the arbiter to raise a request.
   task automatic waitGrant();
      for (int i = 0; i < 12; i++) begin
         if (validDreq != 4'b0000) break;
         tick();
      end
   endtask

   // One complete service of the expected channel.
   task automatic serve(input string tag, input int ch);
      logic [3:0] oh;
      logic [3:0] expDack;
      oh = 4'b0001 << ch;
      waitGrant();
      checkEq({tag, "_vdreq"}, 32'(validDreq), 32'(oh));
      checkEq({tag, "_grantCh"}, 32'(grantCh), 32'(ch));
      validDack = 1'b1;
      tick();
      validDack = 1'b0;
      expDack = commandReg[7] ? oh : ~oh;
      checkEq({tag, "_dackOn"}, 32'(dack), 32'(expDack));
      cycleDone = 1'b1;
      tick();
      cycleDone = 1'b0;
      expDack = commandReg[7] ? 4'b0000 : 4'b1111;
      checkEq({tag, "_dackOff"}, 32'(dack), 32'(expDack));
   endtask

   // Drop every request and let any stale grant withdraw.
   task automatic quiesce();
      dreq       = commandReg[6] ? 4'b1111 : 4'b0000;
      requestReg = 4'b0000;
      repeat (4) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET      = 1'b1;
      dreq       = 4'b0000;
      commandReg = 8'h00;
      maskReg    = 4'b0000;
      requestReg = 4'b0000;
      validDack  = 1'b0;
      cycleDone  = 1'b0;
      repeat (2) tick();
      RESET = 1'b0;
      checkEq("rst_vdreq", 32'(validDreq), 32'h0);
      checkEq("rst_dack", 32'(dack), 32'hF);
      checkEq("rst_gvalid", 32'(grantValid), 32'h0);
      checkEq("rst_ptr", 32'(prioPtr), 32'h0);

      // Two-cycle latency from pin to validDreq.
      dreq = 4'b0100;
      tick();
      checkEq("lat1_vdreq", 32'(validDreq), 32'h0);
      tick();
      checkEq("lat2_vdreq", 32'(validDreq), 32'h4);
      checkEq("lat2_gvalid", 32'(grantValid), 32'h1);
      serve("ch2", 2);
      quiesce();

      // Fixed priority: ch1 beats ch3 every time.
      dreq = 4'b1010;
      serve("fix_a", 1);
      serve("fix_b", 1);
      checkEq("fix_ptr", 32'(prioPtr), 32'h0);
      quiesce();

      // Rotating priority with all channels requesting.
      commandReg = 8'h10;
      dreq = 4'b1111;
      serve("rot0", 0);
      checkEq("rot0_ptr", 32'(prioPtr), 32'h1);
      serve("rot1", 1);
      checkEq("rot1_ptr", 32'(prioPtr), 32'h2);
      serve("rot2", 2);
      checkEq("rot2_ptr", 32'(prioPtr), 32'h3);
      serve("rot3", 3);
      checkEq("rot3_ptr", 32'(prioPtr), 32'h0);
      serve("rot4", 0);
      checkEq("rot4_ptr", 32'(prioPtr), 32'h1);
      quiesce();

      // Masked hardware request, software request grants then withdraws.
      commandReg = 8'h00;
      maskReg    = 4'b0001;
      dreq       = 4'b0001;
      requestReg = 4'b0001;
      waitGrant();
      checkEq("sw_vdreq", 32'(validDreq), 32'h1);
      requestReg = 4'b0000;
      tick();
      checkEq("wd_vdreq", 32'(validDreq), 32'h0);
      checkEq("wd_gvalid", 32'(grantValid), 32'h0);
      checkEq("wd_ptr", 32'(prioPtr), 32'h1);
      repeat (3) tick();
      checkEq("mask_vdreq", 32'(validDreq), 32'h0);

      // validDack beats withdrawal in the same cycle.
      requestReg = 4'b0001;
      waitGrant();
      checkEq("race_vdreq", 32'(validDreq), 32'h1);
      requestReg = 4'b0000;
      validDack  = 1'b1;
      tick();
      validDack = 1'b0;
      checkEq("race_dack", 32'(dack), 32'hE);
      cycleDone = 1'b1;
      tick();
      cycleDone = 1'b0;
      checkEq("race_dackOff", 32'(dack), 32'hF);
      maskReg = 4'b0000;
      quiesce();

      // Active-low DREQ with active-high DACK.
      commandReg = 8'hC0;
      dreq       = 4'b1101;
      serve("pol", 1);
      quiesce();

      // Reset during service.
      commandReg = 8'h00;
      quiesce();
      dreq = 4'b1000;
      waitGrant();
      checkEq("svc_vdreq", 32'(validDreq), 32'h8);
      validDack = 1'b1;
      tick();
      validDack = 1'b0;
      checkEq("svc_dack", 32'(dack), 32'h7);
      RESET = 1'b1;
      dreq  = 4'b0000;
      tick();
      RESET = 1'b0;
      checkEq("mrst_vdreq", 32'(validDreq), 32'h0);
      checkEq("mrst_dack", 32'(dack), 32'hF);
      checkEq("mrst_ptr", 32'(prioPtr), 32'h0);
      checkEq("mrst_gvalid", 32'(grantValid), 32'h0);

      // Disabled controller never grants.
      commandReg = 8'h04;
      dreq       = 4'b1111;
      repeat (4) tick();
      checkEq("dis_vdreq", 32'(validDreq), 32'h0);
      checkEq("dis_gvalid", 32'(grantValid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
